// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet becomes visible downstream only
// after its tlast beat is written, and packets larger than the buffer are discarded.
module axis_packet_fifo #(
  parameter int AXIS_BYTES = 1,
  parameter int DEPTH      = 2048
) (
  input  logic                          clk,
  input  logic                          areset,
  output logic                          axis_i_tready,
  input  logic                          axis_i_tvalid,
  input  logic                          axis_i_tlast,
  input  logic [8*AXIS_BYTES-1:0]       axis_i_tdata,
  input  logic                          axis_o_tready,
  output logic                          axis_o_tvalid,
  output logic                          axis_o_tlast,
  output logic [8*AXIS_BYTES-1:0]       axis_o_tdata,
  output logic                          drop,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int DW = 8 * AXIS_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [0:0] {
    ST_WRITE = 1'b0,
    ST_DROP  = 1'b1
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [PW-1:0]   wr_ptr_r, wr_ptr_nxt_s, wr_inc_s;
  logic [PW-1:0]   commit_ptr_r, commit_ptr_nxt_s;
  logic [PW-1:0]   commit_vis_r;
  logic [PW-1:0]   rd_ptr_r, rd_ptr_nxt_s;
  logic [PW-1:0]   fetch_ptr_r, fetch_ptr_nxt_s;
  logic            out_valid_r, out_valid_nxt_s;
  logic            out_last_r;
  logic [DW-1:0]   out_data_r;
  logic            drop_r, drop_nxt_s;
  logic            in_ready_r, in_ready_nxt_s;
  logic [PW-1:0]   level_r, level_nxt_s;
  logic            in_fire_s, out_fire_s, fetch_s, mem_we_s;
  logic [DW:0]     mem_r [DEPTH];

  assign in_fire_s  = axis_i_tvalid && in_ready_r;
  assign out_fire_s = out_valid_r && axis_o_tready;
  // commit_vis_r lags commit_ptr_r by one cycle, so a fresh packet is first shown two edges after its tlast
  assign fetch_s    = (fetch_ptr_r != commit_vis_r) && (!out_valid_r || axis_o_tready);
  assign wr_inc_s   = wr_ptr_r + PTR_ONE;

  // Write-side state machine: pointer advance, commit on tlast, oversize discard
  always_comb begin
    state_nxt_s      = state_r;
    wr_ptr_nxt_s     = wr_ptr_r;
    commit_ptr_nxt_s = commit_ptr_r;
    drop_nxt_s       = 1'b0;
    mem_we_s         = 1'b0;
    case (state_r)
      ST_WRITE: begin
        if (in_fire_s) begin
          mem_we_s     = 1'b1;
          wr_ptr_nxt_s = wr_inc_s;
          if (axis_i_tlast) begin
            commit_ptr_nxt_s = wr_inc_s;
          end else if ((wr_inc_s - commit_ptr_r) == DEPTH_P) begin
            wr_ptr_nxt_s = commit_ptr_r;
            drop_nxt_s   = 1'b1;
            state_nxt_s  = ST_DROP;
          end else begin
            commit_ptr_nxt_s = commit_ptr_r;
          end
        end else begin
          wr_ptr_nxt_s = wr_ptr_r;
        end
      end
      ST_DROP: begin
        if (in_fire_s && axis_i_tlast) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_WRITE;
      end
    endcase
  end

  // Read-side next state: prefetch into the output register, retire on handshake
  always_comb begin
    rd_ptr_nxt_s    = rd_ptr_r;
    fetch_ptr_nxt_s = fetch_ptr_r;
    out_valid_nxt_s = out_valid_r;
    if (out_fire_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (fetch_s) begin
      fetch_ptr_nxt_s = fetch_ptr_r + PTR_ONE;
      out_valid_nxt_s = 1'b1;
    end else if (out_fire_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Level and input-ready are computed from next pointers so both can be registered
  always_comb begin
    level_nxt_s    = wr_ptr_nxt_s - rd_ptr_nxt_s;
    in_ready_nxt_s = 1'b0;
    if (state_nxt_s == ST_DROP) begin
      in_ready_nxt_s = 1'b1;
    end else begin
      in_ready_nxt_s = (level_nxt_s < DEPTH_P);
    end
  end

  // Control and pointer registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r      <= ST_WRITE;
      wr_ptr_r     <= {PW{1'b0}};
      commit_ptr_r <= {PW{1'b0}};
      commit_vis_r <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      fetch_ptr_r  <= {PW{1'b0}};
      out_valid_r  <= 1'b0;
      drop_r       <= 1'b0;
      in_ready_r   <= 1'b0;
      level_r      <= {PW{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      commit_ptr_r <= commit_ptr_nxt_s;
      commit_vis_r <= commit_ptr_r;
      rd_ptr_r     <= rd_ptr_nxt_s;
      fetch_ptr_r  <= fetch_ptr_nxt_s;
      out_valid_r  <= out_valid_nxt_s;
      drop_r       <= drop_nxt_s;
      in_ready_r   <= in_ready_nxt_s;
      level_r      <= level_nxt_s;
    end
  end

  // Output register doubles as the synchronous RAM read register; holds while stalled
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_data_r <= {DW{1'b0}};
      out_last_r <= 1'b0;
    end else if (fetch_s) begin
      out_data_r <= mem_r[fetch_ptr_r[AW-1:0]][DW-1:0];
      out_last_r <= mem_r[fetch_ptr_r[AW-1:0]][DW];
    end else begin
      out_data_r <= out_data_r;
      out_last_r <= out_last_r;
    end
  end

  // Packet storage, {tlast, tdata} per beat
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {axis_i_tlast, axis_i_tdata};
    end
  end

  assign axis_i_tready = in_ready_r;
  assign axis_o_tvalid = out_valid_r;
  assign axis_o_tlast  = out_last_r;
  assign axis_o_tdata  = out_data_r;
  assign drop          = drop_r;
  assign level         = level_r;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed + random bench for axis_packet_fifo: dut 0 uses DEPTH=2048, dut 1 uses DEPTH=16.
module tb_axis_packet_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            areset;
  logic [1:0]      i_valid, i_last, i_ready, o_ready, o_valid, o_last, drop_o;
  logic [1:0][7:0] i_data, o_data;
  logic [11:0]     level0;
  logic [4:0]      level1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_cnt[2], in_acc[2], drop_cnt[2], drop_at[2], stall_cnt[2];
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  axis_packet_fifo #(.AXIS_BYTES(1), .DEPTH(2048)) dut_big (
    .clk(clk), .areset(areset),
    .axis_i_tready(i_ready[0]), .axis_i_tvalid(i_valid[0]), .axis_i_tlast(i_last[0]), .axis_i_tdata(i_data[0]),
    .axis_o_tready(o_ready[0]), .axis_o_tvalid(o_valid[0]), .axis_o_tlast(o_last[0]), .axis_o_tdata(o_data[0]),
    .drop(drop_o[0]), .level(level0));

  axis_packet_fifo #(.AXIS_BYTES(1), .DEPTH(16)) dut_small (
    .clk(clk), .areset(areset),
    .axis_i_tready(i_ready[1]), .axis_i_tvalid(i_valid[1]), .axis_i_tlast(i_last[1]), .axis_i_tdata(i_data[1]),
    .axis_o_tready(o_ready[1]), .axis_o_tvalid(o_valid[1]), .axis_o_tlast(o_last[1]), .axis_o_tdata(o_data[1]),
    .drop(drop_o[1]), .level(level1));

  always @(posedge clk) cyc++;

  // Monitor: input/drop bookkeeping and scoreboard comparison of every output handshake
  always @(negedge clk) begin
    logic [8:0] got_v, exp_v;
    for (int d = 0; d < 2; d++) begin
      if (drop_o[d]) begin
        drop_cnt[d]++;
        drop_at[d] = in_acc[d];
      end
      if (i_valid[d] && i_ready[d]) in_acc[d]++;
      if (o_valid[d] && o_ready[d]) begin
        got_v = {o_last[d], o_data[d]};
        exp_v = 9'bx;
        if (d == 0 && q0.size() > 0) exp_v = q0.pop_front();
        if (d == 1 && q1.size() > 0) exp_v = q1.pop_front();
        checks++;
        assert (got_v === exp_v) else begin
          failures++;
          $error("FAIL out_beat dut%0d beat%0d observed=%h expected=%h", d, out_cnt[d], got_v, exp_v);
        end
        out_cnt[d]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic send_beat(input int d, input logic [7:0] data, input logic last, input bit expect_out);
    bit acc;
    acc = 1'b0;
    i_valid[d] = 1'b1;
    i_data[d]  = data;
    i_last[d]  = last;
    if (expect_out) begin
      if (d == 0) q0.push_back({last, data});
      else        q1.push_back({last, data});
    end
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      acc = i_ready[d];
      if (!acc) stall_cnt[d]++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      failures++;
      $error("FAIL accept_timeout dut%0d observed=0 expected=1", d);
    end
  endtask

  task automatic send_pkt(input int d, input int len, input logic [7:0] base, input bit expect_out);
    for (int i = 0; i < len; i++) send_beat(d, base + 8'(i), (i == len - 1), expect_out);
  endtask

  task automatic idle(input int d);
    i_valid[d] = 1'b0;
    i_last[d]  = 1'b0;
  endtask

  task automatic wait_empty(input int d, input int budget, input string tag);
    for (int n = 0; n < budget && qsize(d) != 0; n++) tick();
    chk(tag, qsize(d), 0);
  endtask

  initial begin
    int base_i, c0, a0, s0, d0;
    logic [63:0] pat;
    logic [7:0] held;
    bit done;
    i_valid = 2'b00; i_last = 2'b00; i_data = '0; o_ready = 2'b00;
    for (int d = 0; d < 2; d++) begin
      out_cnt[d] = 0; in_acc[d] = 0; drop_cnt[d] = 0; drop_at[d] = 0; stall_cnt[d] = 0;
    end
    areset = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_i_tready", i_ready[d], 0);
      chk("rst_o_tvalid", o_valid[d], 0);
      chk("rst_o_tlast", o_last[d], 0);
      chk("rst_o_tdata", o_data[d], 0);
      chk("rst_drop", drop_o[d], 0);
    end
    chk("rst_level0", level0, 0);
    chk("rst_level1", level1, 0);
    areset = 1'b0;
    #1;
    chk("tready_before_edge", i_ready[0], 0);
    tick();
    chk("tready_after_edge0", i_ready[0], 1);
    chk("tready_after_edge1", i_ready[1], 1);

    // Single 22-beat packet, latency and contiguous output
    o_ready[0] = 1'b1;
    pat = 64'hDEADBEEFCAFECAFE;
    base_i = out_cnt[0];
    for (int i = 0; i < 22; i++) send_beat(0, pat[63 - 8 * (i % 8) -: 8], (i == 21), 1'b1);
    idle(0);
    chk("sf_no_early_out", out_cnt[0] - base_i, 0);
    chk("lat_k", o_valid[0], 0);
    tick();
    chk("lat_k1", o_valid[0], 0);
    tick();
    chk("lat_k2", o_valid[0], 1);
    repeat (22) tick();
    chk("single_contig", out_cnt[0] - base_i, 22);
    chk("single_q_empty", qsize(0), 0);

    // Back-to-back 5,1,64 held downstream, then released
    o_ready[0] = 1'b0;
    c0 = cyc;
    send_pkt(0, 5, 8'h10, 1'b1);
    send_pkt(0, 1, 8'h20, 1'b1);
    send_pkt(0, 64, 8'h30, 1'b1);
    idle(0);
    chk("b2b_in_rate", cyc - c0, 70);
    tick();
    tick();
    chk("b2b_level", level0, 70);
    held = o_data[0];
    repeat (3) tick();
    chk("hold_valid", o_valid[0], 1);
    chk("hold_data", o_data[0], held);
    chk("hold_first", {o_last[0], o_data[0]}, 9'h010);
    base_i = out_cnt[0];
    o_ready[0] = 1'b1;
    repeat (70) tick();
    chk("b2b_contig", out_cnt[0] - base_i, 70);
    chk("b2b_level_zero", level0, 0);
    chk("b2b_q_empty", qsize(0), 0);

    // Backpressure on DEPTH=16
    o_ready[1] = 1'b0;
    a0 = in_acc[1];
    fork
      begin
        send_pkt(1, 10, 8'h40, 1'b1);
        send_pkt(1, 10, 8'h50, 1'b1);
        idle(1);
      end
      begin
        for (int n = 0; n < 200 && level1 != 5'd16; n++) tick();
        chk("bp_level16", level1, 16);
        chk("bp_tready_low", i_ready[1], 0);
        repeat (5) tick();
        chk("bp_tready_still_low", i_ready[1], 0);
        chk("bp_accepted", in_acc[1] - a0, 16);
        o_ready[1] = 1'b1;
      end
    join
    wait_empty(1, 300, "bp_drain");
    repeat (3) tick();
    chk("bp_level_zero", level1, 0);

    // Oversize packet discard on DEPTH=16
    base_i = out_cnt[1];
    a0 = in_acc[1];
    d0 = drop_cnt[1];
    s0 = stall_cnt[1];
    send_pkt(1, 40, 8'hA0, 1'b0);
    send_pkt(1, 3, 8'h70, 1'b1);
    idle(1);
    wait_empty(1, 100, "ovs_drain");
    repeat (4) tick();
    chk("ovs_drop_once", drop_cnt[1] - d0, 1);
    chk("ovs_drop_at16", drop_at[1] - a0, 16);
    chk("ovs_no_stall", stall_cnt[1] - s0, 0);
    chk("ovs_out_count", out_cnt[1] - base_i, 3);

    // Reset with a half-read packet and a partial packet in flight
    o_ready[0] = 1'b0;
    send_pkt(0, 8, 8'hC0, 1'b1);
    idle(0);
    repeat (3) tick();
    o_ready[0] = 1'b1;
    repeat (4) tick();
    o_ready[0] = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(0, 8'hE0 + 8'(i), 1'b0, 1'b0);
    areset = 1'b1;
    #1;
    chk("mrst_o_tvalid", o_valid[0], 0);
    chk("mrst_o_tlast", o_last[0], 0);
    chk("mrst_o_tdata", o_data[0], 0);
    chk("mrst_i_tready", i_ready[0], 0);
    chk("mrst_level", level0, 0);
    q0.delete();
    q1.delete();
    idle(0);
    tick();
    tick();
    areset = 1'b0;
    tick();
    o_ready[0] = 1'b1;
    base_i = out_cnt[0];
    send_pkt(0, 4, 8'h55, 1'b1);
    idle(0);
    wait_empty(0, 50, "mrst_new_pkt");
    chk("mrst_out_count", out_cnt[0] - base_i, 4);

    // Random traffic, 10000 beats, packets of 1-20 beats
    d0 = drop_cnt[0];
    done = 1'b0;
    fork
      begin
        int b, len;
        b = 0;
        while (b < 10000) begin
          len = $urandom_range(1, 20);
          if (len > 10000 - b) len = 10000 - b;
          for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 1) == 0) begin
              idle(0);
              tick();
            end
            send_beat(0, 8'($urandom_range(0, 255)), (i == len - 1), 1'b1);
          end
          b += len;
        end
        idle(0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          o_ready[0] = 1'($urandom_range(0, 1));
          tick();
        end
        o_ready[0] = 1'b1;
      end
    join
    wait_empty(0, 500, "rand_drain");
    repeat (3) tick();
    chk("rand_no_drop", drop_cnt[0] - d0, 0);
    chk("rand_level_zero", level0, 0);
    chk("final_q1_empty", qsize(1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_packet_fifo.md
AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 The block SHALL have parameter AXIS_BYTES, default 1, meaning the tdata width in bytes on both ports.
REQ-002 The block SHALL have parameter DEPTH, default 2048, meaning the storage in beats; it is a power of two and at least 4.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port areset, input, width 1, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have ports axis_i_tready (output, 1), axis_i_tvalid (input, 1), axis_i_tlast (input, 1) and axis_i_tdata (input, 8*AXIS_BYTES), the upstream stream from eth_framer.
REQ-006 The block SHALL have ports axis_o_tready (input, 1), axis_o_tvalid (output, 1), axis_o_tlast (output, 1) and axis_o_tdata (output, 8*AXIS_BYTES), the downstream stream to axis_spacer.
REQ-007 The block SHALL have port drop, output, width 1, a one-cycle pulse marking an oversize packet that was discarded.
REQ-008 The block SHALL have port level, output, width clog2(DEPTH)+1, the number of stored beats, committed and uncommitted.

Function
REQ-009 Store-and-forward: no beat of a packet SHALL appear on axis_o until the tlast beat of that packet has been accepted.
REQ-010 Storage: RAM of DEPTH entries of {tlast, tdata}. Pointers wr_ptr, commit_ptr and rd_ptr are each clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-011 Input handshake: a beat is accepted when axis_i_tvalid && axis_i_tready. axis_i_tready = !areset && (state==DROP || wr_ptr-rd_ptr < DEPTH).
REQ-012 State machine, state WRITE: each accepted beat is written at wr_ptr, then wr_ptr is incremented. An accepted beat with tlast sets commit_ptr to the new wr_ptr on the same edge.
REQ-013 WRITE to DROP: if a non-tlast beat is accepted and wr_ptr-commit_ptr reaches DEPTH, then wr_ptr is set to commit_ptr, drop is pulsed and the state goes to DROP.
REQ-014 State DROP: tready=1; accepted beats are discarded and no pointers move. An accepted tlast beat returns the state to WRITE.
REQ-015 Buffer full with committed data present (wr_ptr-rd_ptr==DEPTH, commit_ptr!=rd_ptr): tready=0 (backpressure, no drop).
REQ-016 Output: data is available when rd_ptr!=commit_ptr. RAM read is synchronous into a prefetch output register. axis_o_tvalid, tdata and tlast come from that register.
REQ-017 Latency: with an empty FIFO and the tlast beat accepted at edge k, axis_o_tvalid SHALL be 1 from edge k+2.
REQ-018 Throughput: with axis_o_tready held high, one beat per cycle is sustained, including back-to-back packets with no idle cycle between a tlast and the next first beat.
REQ-019 While axis_o_tvalid=1 and axis_o_tready=0, axis_o_tdata and axis_o_tlast SHALL hold stable.
REQ-020 Simultaneous read and write in one cycle are both honoured. level = wr_ptr - rd_ptr, counting beats in the output register.
REQ-021 The output side never reads past commit_ptr. A partial packet in WRITE is invisible downstream.

Reset
REQ-022 While areset=1: axis_i_tready=0, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tdata=0, drop=0, level=0, all pointers=0, state=WRITE.
REQ-023 Reset asserted mid-packet (either side) SHALL discard all stored and in-flight data. After deassertion the first accepted beat is treated as the start of a new packet.
REQ-024 axis_i_tready SHALL rise no earlier than the first rising edge after areset deasserts.

Verification
REQ-025 Single packet: send 22 beats (framed DEADBEEFCAFECAFE) with axis_o_tready=1 -> axis_o_tvalid=0 until the tlast handshake edge k plus 2. Then 22 contiguous beats are output with identical data and tlast only on beat 22.
REQ-026 Back-to-back: three packets of 5, 1 and 64 beats with tready=1 -> 70 output beats with no gaps once streaming starts, and tlast on beats 5, 6 and 70.
REQ-027 Backpressure: DEPTH=16, two 10-beat packets, axis_o_tready=0 -> axis_i_tready drops at level=16. Release downstream -> both packets are delivered intact and level returns to 0.
REQ-028 Oversize: DEPTH=16, empty FIFO, one 40-beat packet followed by a 3-beat packet -> drop pulses once at the 16th beat and tready stays 1. Only the 3-beat packet is output.
REQ-029 Reset mid-operation: assert areset after 7 beats of a 12-beat packet while a prior packet is half read -> outputs reach their reset values immediately and level=0. A new 4-beat packet then passes intact.
REQ-030 Random: random tvalid/tready at 50% duty for 10000 beats, packet lengths 1-20 -> the output sequence equals the input sequence and no drop pulse occurs.
